// File: rtl/mem_target.sv
// Register-file memory target: single-cycle writes, RD_LAT-cycle registered reads,
// a hardware clear sequencer and saturating write/drop counters.
module mem_target #(
  parameter int                 ADDR_W   = 4,
  parameter int                 DATA_W   = 8,
  parameter int                 RD_LAT   = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              wr_lock,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [15:0]       wr_cnt,
  output logic [7:0]        drop_cnt,
  output logic              dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_target: RD_LAT must be in 1..4");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   pipe_q [RD_LAT];

  logic                wr_acc, wr_drop, clr_wr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   stage0;

  // Write contract: an initiator write (we=1) is accepted at the edge only when
  // wr_lock=0 and no clear is running; otherwise it is dropped and counted.
  assign clr_wr  = (state_q == CLEAR);
  assign wr_acc  = we & ~wr_lock & ~clr_wr;
  assign wr_drop = we & ~wr_acc;

  always_comb begin
    mem_we    = wr_acc | clr_wr;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (clr_wr) begin
      mem_waddr = clr_ptr_q;
      mem_wdata = INIT_VAL;
    end
  end

  // Write-first: whatever lands this edge on the read address is what we return.
  always_comb begin
    stage0 = mem_q[addr];
    if (mem_we && (mem_waddr == addr)) begin
      stage0 = mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_acc && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (wr_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wr_cnt_q   <= wr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT_VAL;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rdata     = pipe_q[RD_LAT-1];
  assign busy      = clr_wr;
  assign clr_done  = clr_wr & (&clr_ptr_q);
  assign wr_cnt    = wr_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_target.sv
// Bench for mem_target: two instances (RD_LAT 1 and 3) share stimulus and are
// compared every cycle against an array-based model of the memory.
module tb_mem_target;

  localparam logic [7:0] INIT = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, wr_lock, clr_req;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata1, rdata3;
  logic        busy1, busy3, done1, done3, st1, st3;
  logic [15:0] wr_cnt1, wr_cnt3;
  logic [7:0]  drop1, drop3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q3[$];

  logic [7:0] m_mem [16];
  bit         m_busy;
  int         m_ptr, m_wr, m_drop;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_target #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .INIT_VAL(INIT)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata1),
    .wr_lock(wr_lock), .clr_req(clr_req), .busy(busy1), .clr_done(done1),
    .wr_cnt(wr_cnt1), .drop_cnt(drop1), .dbg_state(st1)
  );

  mem_target #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .INIT_VAL(INIT)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata3),
    .wr_lock(wr_lock), .clr_req(clr_req), .busy(busy3), .clr_done(done3),
    .wr_cnt(wr_cnt3), .drop_cnt(drop3), .dbg_state(st3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = INIT;
    m_busy = 1'b0;
    m_ptr  = 0;
    m_wr   = 0;
    m_drop = 0;
    exp_q1.delete();
    exp_q3.delete();
    exp_q3.push_back(8'h00);
    exp_q3.push_back(8'h00);
  endtask

  // One clock of stimulus; the model advances to its post-edge state before the edge.
  task automatic step(input bit we_v, input bit lock_v, input bit clr_v,
                      input logic [3:0] a, input logic [7:0] d);
    bit         acc;
    logic [7:0] rd;
    we = we_v; wr_lock = lock_v; clr_req = clr_v; addr = a; wdata = d;
    acc = we_v && !lock_v && !m_busy;
    if (acc) rd = d;
    else if (m_busy && m_ptr == int'(a)) rd = INIT;
    else rd = m_mem[a];
    exp_q1.push_back(rd);
    exp_q3.push_back(rd);
    if (acc) begin
      m_mem[a] = d;
      if (m_wr < 65535) m_wr++;
    end else if (we_v) begin
      if (m_drop < 255) m_drop++;
    end
    if (m_busy) begin
      m_mem[m_ptr] = INIT;
      if (m_ptr == 15) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end else begin
        m_ptr++;
      end
    end else if (clr_v) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (exp_q1.size() == 0) check("exp_q1_underflow", 32'd1, 32'd0);
      else check("rdata_lat1", rdata1, exp_q1.pop_front());
      if (exp_q3.size() == 0) check("exp_q3_underflow", 32'd1, 32'd0);
      else check("rdata_lat3", rdata3, exp_q3.pop_front());
      check("busy", busy1, m_busy);
      check("busy_lat3", busy3, m_busy);
      check("clr_done", done1, (m_busy && m_ptr == 15));
      check("dbg_state", st1, m_busy);
      check("wr_cnt", wr_cnt1, m_wr);
      check("drop_cnt", drop1, m_drop);
      check("wr_cnt_lat3", wr_cnt3, m_wr);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int busy_n, done_n, drop_exp;
    rst_n = 1'b0; we = 1'b0; wr_lock = 1'b0; clr_req = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #1;
    check("rst_rdata1", rdata1, 8'h00);
    check("rst_rdata3", rdata3, 8'h00);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_wr_cnt", wr_cnt1, 16'h0);
    check("rst_drop_cnt", drop1, 8'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    step(0, 0, 0, 4'h9, 8'h00);
    check("t0_init_read", rdata1, INIT);

    // write then read back
    step(1, 0, 0, 4'h3, 8'hA5);
    step(0, 0, 0, 4'h3, 8'h00);
    check("t1_rdata", rdata1, 8'hA5);
    check("t1_wr_cnt", wr_cnt1, 16'd1);

    // read during write, same address
    step(1, 0, 0, 4'h7, 8'h3C);
    check("t2_fwd_lat1", rdata1, 8'h3C);
    step(0, 0, 0, 4'h0, 8'h00);
    step(0, 0, 0, 4'h0, 8'h00);
    check("t2_fwd_lat3", rdata3, 8'h3C);

    // locked write is dropped
    step(1, 0, 0, 4'h2, 8'h5A);
    step(1, 1, 0, 4'h2, 8'hFF);
    step(0, 0, 0, 4'h2, 8'h00);
    check("t3_lock_keep", rdata1, 8'h5A);
    check("t3_drop_cnt", drop1, 8'd1);
    check("t3_wr_cnt", wr_cnt1, 16'd3);

    // random traffic including occasional clears
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 20 && m_busy; i++) step(0, 0, 0, 4'h0, 8'h00);

    // clear sequence with writes and a second request while busy
    for (int i = 0; i < 16; i++) step(1, 0, 0, 4'(i), 8'h11);
    drop_exp = m_drop + 16;
    if (drop_exp > 255) drop_exp = 255;
    step(0, 0, 1, 4'h0, 8'h00);
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy1) busy_n++;
      if (done1) done_n++;
      step((k < 16), 0, (k == 4), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    check("t4_busy_cycles", busy_n, 16);
    check("t4_done_pulses", done_n, 1);
    check("t4_drop_cnt", drop1, drop_exp);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 4'(i), 8'h00);
      check("t4_cleared", rdata1, INIT);
    end

    // counter saturation
    for (int i = 0; i < 70000; i++) begin
      step(1, 0, 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    check("t5_wr_sat", wr_cnt1, 16'hFFFF);
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    check("t5_drop_sat", drop1, 8'hFF);

    // reset in the middle of a clear
    step(1, 0, 0, 4'h9, 8'h77);
    step(0, 0, 1, 4'h0, 8'h00);
    for (int i = 0; i < 20 && !(m_busy && m_ptr == 5); i++) step(0, 0, 0, 4'h9, 8'h00);
    check("t6_reached_ptr5", (m_busy && m_ptr == 5), 1'b1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t6_busy", busy1, 1'b0);
    check("t6_done", done1, 1'b0);
    check("t6_rdata1", rdata1, 8'h00);
    check("t6_rdata3", rdata3, 8'h00);
    check("t6_wr_cnt", wr_cnt1, 16'h0);
    check("t6_drop_cnt", drop1, 8'h0);
    model_reset();
    we = 1'b0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(0, 0, 0, 4'h9, 8'h00);
    check("t6_read9", rdata1, INIT);
    check("t6_no_done", done1, 1'b0);
    step(0, 0, 0, 4'h9, 8'h00);
    step(0, 0, 0, 4'h9, 8'h00);
    check("t6_read9_lat3", rdata3, INIT);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
